dcache_mem_responder: RTL and testbench

Memory-side responder for the data-cache bus: it answers the cache's `dREN`/`dWEN`/`daddr`/`dstore` requests with `dload` and `dwait` from a word-addressed backing RAM. It models a fixed number of wait states per access, giving cache and datapath tests a deterministic, latency-configurable memory. It sits below the data cache in simulation and FPGA test builds, in place of the shared memory controller.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/dcache_mem_responder_if.sv | 18 +
 rtl/dmem_resp_ram.sv | 34 +++
 rtl/dcache_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_dcache_mem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types plus the constants used by the data-cache memory responder.
package cpu_types_pkg;

    // One 32-bit bus word (address or data).
    typedef logic [31:0] word_t;

    // Responder FSM states.
    typedef enum logic {RESP_IDLE, RESP_BUSY} resp_state_t;

    // Largest wait-state count the 4-bit counter can express.
    localparam int unsigned DMEM_LAT_MAX = 15;
    localparam int unsigned DMEM_CNT_W   = 4;

endpackage

// File: rtl/dcache_mem_responder_if.sv
// Data-cache <-> memory bus.
//   master (cache):     drives dREN, dWEN, daddr, dstore; receives dload, dwait
//   slave  (responder): receives the request; drives dload, dwait
interface dcache_mem_responder_if;
    import cpu_types_pkg::*;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    word_t dload;
    logic  dwait;

    modport master (output dREN, output dWEN, output daddr, output dstore,
                    input  dload, input  dwait);
    modport slave  (input  dREN, input  dWEN, input  daddr, input  dstore,
                    output dload, output dwait);
endinterface

// File: rtl/dmem_resp_ram.sv
// Word-addressed backing RAM: synchronous write, asynchronous read, single port.
//   clk     : write clock
//   we      : write enable, sampled on the rising edge
//   addr    : word index shared by read and write
//   wdata   : write data
//   rdata_c : combinational read data at addr
// Contents are not reset.
module dmem_resp_ram
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             wdata,
    output word_t             rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    word_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port.
    assign rdata_c = mem[addr];

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data-cache bus with a fixed number of wait states.
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   bus       : dcache_mem_responder_if.slave (dREN/dWEN/daddr/dstore in, dload/dwait out)
//   rd_count, wr_count, stall_count : completed reads / writes / stalled cycles
//             (present only when DMEM_RESP_STATS_EN is defined)
// dwait and dload are combinational from the request so that a completion is
// visible in the same cycle the access finishes.
module dcache_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic CLK,
    input  logic nRST,
    dcache_mem_responder_if.slave bus
`ifdef DMEM_RESP_STATS_EN
    ,
    output word_t rd_count,
    output word_t wr_count,
    output word_t stall_count
`endif
);

    localparam int unsigned CNT_W = DMEM_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    // Elaboration-time range check of the wait-state count.
    if (LATENCY > DMEM_LAT_MAX) begin : g_latency_check
        $error("dcache_mem_responder: LATENCY %0d exceeds %0d", LATENCY, DMEM_LAT_MAX);
    end

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cap_wr_q, cap_wr_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;

    logic              req_c;
    logic              req_wr_c;
    logic [ADDR_W-1:0] idx_c;
    logic              done_c;
    logic              dwait_c;
    logic              we_c;
    word_t             rdata_c;
    word_t             dload_c;

    // Request decode: both strobes high counts as a write.
    assign req_c    = bus.dREN | bus.dWEN;
    assign req_wr_c = bus.dWEN;
    assign idx_c    = bus.daddr[ADDR_W+1:2];

    // Byte offset and upper bits alias away.
    logic unused_addr;
    assign unused_addr = ^{bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};

    // State, counter and request-capture registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RESP_IDLE;
            cnt_q     <= '0;
            cap_wr_q  <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_wr_q  <= cap_wr_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    // Next state, wait-state counting, abort on request change, completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_wr_d  = cap_wr_q;
        cap_idx_d = cap_idx_q;
        done_c    = 1'b0;
        dwait_c   = 1'b0;
        case (state_q)
            RESP_IDLE: begin
                if (req_c) begin
                    if (LATENCY == 0) begin
                        done_c = 1'b1;
                    end else begin
                        state_d   = RESP_BUSY;
                        cnt_d     = '0;
                        cap_wr_d  = req_wr_c;
                        cap_idx_d = idx_c;
                        dwait_c   = 1'b1;
                    end
                end
            end
            RESP_BUSY: begin
                if (req_c && (req_wr_c == cap_wr_q) && (idx_c == cap_idx_q)) begin
                    if (cnt_q == CNT_LAST) begin
                        done_c  = 1'b1;
                        state_d = RESP_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        dwait_c = 1'b1;
                    end
                end else begin
                    // Aborted access: restart the wait on whatever is asked now.
                    cnt_d   = '0;
                    dwait_c = 1'b1;
                    if (req_c) begin
                        cap_wr_d  = req_wr_c;
                        cap_idx_d = idx_c;
                    end else begin
                        state_d = RESP_IDLE;
                    end
                end
            end
            default: state_d = RESP_IDLE;
        endcase
        // Reset holds the cache off and blocks any completion.
        if (!nRST) begin
            dwait_c = 1'b1;
            done_c  = 1'b0;
        end
    end

    assign we_c    = done_c & req_wr_c;
    assign dload_c = (done_c && !req_wr_c) ? rdata_c : '0;

    assign bus.dwait = dwait_c;
    assign bus.dload = dload_c;

    dmem_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK),
        .we      (we_c),
        .addr    (idx_c),
        .wdata   (bus.dstore),
        .rdata_c (rdata_c)
    );

`ifdef DMEM_RESP_STATS_EN
    // Access statistics, wrapping at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (done_c && !req_wr_c) begin
                rd_count <= rd_count + 32'd1;
            end
            if (we_c) begin
                wr_count <= wr_count + 32'd1;
            end
            if (dwait_c) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: three instances (LATENCY 2, 0, 3; ADDR_W 10)
// driven by directed steps and random accesses, checked against a word-indexed
// reference memory and expected cycle counts. Statistics are checked when
// DMEM_RESP_STATS_EN is defined.
module tb_dcache_mem_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 0;
    localparam int unsigned LAT2 = 3;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    logic [2:0] ren;
    logic [2:0] wen;
    word_t      addr_v [3];
    word_t      data_v [3];
    logic [2:0] dw;
    word_t      dl [3];

    dcache_mem_responder_if bus0 ();
    dcache_mem_responder_if bus1 ();
    dcache_mem_responder_if bus2 ();

    assign bus0.dREN = ren[0];  assign bus0.dWEN = wen[0];
    assign bus0.daddr = addr_v[0]; assign bus0.dstore = data_v[0];
    assign bus1.dREN = ren[1];  assign bus1.dWEN = wen[1];
    assign bus1.daddr = addr_v[1]; assign bus1.dstore = data_v[1];
    assign bus2.dREN = ren[2];  assign bus2.dWEN = wen[2];
    assign bus2.daddr = addr_v[2]; assign bus2.dstore = data_v[2];
    assign dw[0] = bus0.dwait; assign dl[0] = bus0.dload;
    assign dw[1] = bus1.dwait; assign dl[1] = bus1.dload;
    assign dw[2] = bus2.dwait; assign dl[2] = bus2.dload;

`ifdef DMEM_RESP_STATS_EN
    word_t rdc [3];
    word_t wrc [3];
    word_t stc [3];
`endif

    dcache_mem_responder #(.LATENCY(LAT0), .ADDR_W(10)) dut0 (
        .CLK (clk), .nRST (nRST), .bus (bus0)
`ifdef DMEM_RESP_STATS_EN
        , .rd_count (rdc[0]), .wr_count (wrc[0]), .stall_count (stc[0])
`endif
    );
    dcache_mem_responder #(.LATENCY(LAT1), .ADDR_W(10)) dut1 (
        .CLK (clk), .nRST (nRST), .bus (bus1)
`ifdef DMEM_RESP_STATS_EN
        , .rd_count (rdc[1]), .wr_count (wrc[1]), .stall_count (stc[1])
`endif
    );
    dcache_mem_responder #(.LATENCY(LAT2), .ADDR_W(10)) dut2 (
        .CLK (clk), .nRST (nRST), .bus (bus2)
`ifdef DMEM_RESP_STATS_EN
        , .rd_count (rdc[2]), .wr_count (wrc[2]), .stall_count (stc[2])
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference memory keyed by instance*4096 + word index; expected statistics.
    word_t mem [int];
    int    exp_rd [3];
    int    exp_wr [3];
    int    exp_st [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(LAT0) : ((d == 1) ? int'(LAT1) : int'(LAT2));
    endfunction

    function automatic int key_of(input int d, input word_t a);
        return d * 4096 + int'((a >> 2) % 32'd1024);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access held until completion; entered and left just after a rising edge.
    // Then one idle cycle is checked.
    task automatic access(input int d, input bit wr, input bit both,
                          input word_t a, input word_t data, input string tag);
        int lat = lat_of(d);
        int key = key_of(d, a);
        ren[d]    = wr ? both : 1'b1;
        wen[d]    = wr;
        addr_v[d] = a;
        data_v[d] = data;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk({tag, "_dwait"}, 32'(dw[d]), 32'(k < lat));
            if (k == lat) begin
                if (wr) chk({tag, "_dload_w"}, dl[d], 32'h0);
                else    chk({tag, "_dload_r"}, dl[d], mem[key]);
            end
            @(posedge clk); #1;
        end
        ren[d] = 1'b0;
        wen[d] = 1'b0;
        if (wr) begin
            mem[key] = data;
            exp_wr[d]++;
        end else begin
            exp_rd[d]++;
        end
        exp_st[d] += lat;
        @(negedge clk);
        chk({tag, "_idle_dwait"}, 32'(dw[d]), 32'h0);
        chk({tag, "_idle_dload"}, dl[d], 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        nRST = 1'b0;
        ren = '0;
        wen = '0;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = '0;
            data_v[i] = '0;
            exp_rd[i] = 0;
            exp_wr[i] = 0;
            exp_st[i] = 0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_dwait%0d", i), 32'(dw[i]), 32'h1);
            chk($sformatf("reset_dload%0d", i), dl[i], 32'h0);
`ifdef DMEM_RESP_STATS_EN
            chk($sformatf("reset_rd%0d", i), rdc[i], 32'h0);
            chk($sformatf("reset_st%0d", i), stc[i], 32'h0);
`endif
        end
        @(posedge clk); #1;
        nRST = 1'b1;
        @(negedge clk);
        chk("idle_dwait0", 32'(dw[0]), 32'h0);
        @(posedge clk); #1;

        // LATENCY=2 write/read.
        access(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, "l2_w40");
        access(0, 1'b0, 1'b0, 32'h40, 32'h0, "l2_r40");
        chk("l2_model40", mem[key_of(0, 32'h40)], 32'hDEADBEEF);

        // LATENCY=0: no wait states, data in the request cycle.
        access(1, 1'b1, 1'b0, 32'h100, 32'h12345678, "l0_w100");
        access(1, 1'b0, 1'b0, 32'h100, 32'h0, "l0_r100");

        // Address aliasing above bit ADDR_W+1.
        access(0, 1'b1, 1'b0, 32'h0000_1004, 32'hA5A5A5A5, "alias_w");
        access(0, 1'b0, 1'b0, 32'h0000_0004, 32'h0, "alias_r");

        // LATENCY=3: address changes mid-access, wait restarts, only new word written.
        access(2, 1'b1, 1'b0, 32'h80, 32'h1111_0080, "ab_pre80");
        access(2, 1'b1, 1'b0, 32'h84, 32'h1111_0084, "ab_pre84");
        ren[2] = 1'b0; wen[2] = 1'b1; addr_v[2] = 32'h80; data_v[2] = 32'hCAFE_F00D;
        @(negedge clk); chk("ab_c0", 32'(dw[2]), 32'h1);
        @(posedge clk); #1;
        @(negedge clk); chk("ab_c1", 32'(dw[2]), 32'h1);
        @(posedge clk); #1;
        addr_v[2] = 32'h84;
        @(negedge clk); chk("ab_switch", 32'(dw[2]), 32'h1);
        for (int j = 0; j < int'(LAT2); j++) begin
            @(posedge clk); #1;
            @(negedge clk); chk($sformatf("ab_after%0d", j), 32'(dw[2]), 32'(j < int'(LAT2) - 1));
        end
        @(posedge clk); #1;
        wen[2] = 1'b0;
        mem[key_of(2, 32'h84)] = 32'hCAFE_F00D;
        exp_wr[2]++;
        exp_st[2] += 2 + int'(LAT2);
        access(2, 1'b0, 1'b0, 32'h80, 32'h0, "ab_r80");
        access(2, 1'b0, 1'b0, 32'h84, 32'h0, "ab_r84");

        // Reset during the second wait cycle of a write to 0x40.
        ren[0] = 1'b0; wen[0] = 1'b1; addr_v[0] = 32'h40; data_v[0] = 32'hBAD0_BAD0;
        @(negedge clk); chk("rst_w_c0", 32'(dw[0]), 32'h1);
        @(posedge clk); #1;
        nRST = 1'b0;
        @(negedge clk);
        chk("rst_dwait0", 32'(dw[0]), 32'h1);
        chk("rst_dload0", dl[0], 32'h0);
        chk("rst_dwait1", 32'(dw[1]), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wen[0] = 1'b0;
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 0; exp_wr[i] = 0; exp_st[i] = 0;
        end

        // Three reads and two writes at LATENCY=2; first read shows 0x40 untouched.
        access(0, 1'b0, 1'b0, 32'h40, 32'h0, "rst_r40");
        access(0, 1'b1, 1'b0, 32'h48, 32'h0BAD_CAFE, "st_w48");
        access(0, 1'b0, 1'b0, 32'h48, 32'h0, "st_r48");
        access(0, 1'b1, 1'b1, 32'h4C, 32'h7777_1234, "st_w4c_both");
        access(0, 1'b0, 1'b0, 32'h4C, 32'h0, "st_r4c");
`ifdef DMEM_RESP_STATS_EN
        chk("stats_rd", rdc[0], 32'd3);
        chk("stats_wr", wrc[0], 32'd2);
        chk("stats_stall", stc[0], 32'd10);
`endif

        // Random accesses against the reference memory.
        for (int i = 0; i < 60; i++) begin
            int    d;
            bit    wr;
            bit    both;
            word_t a;
            d    = int'($urandom_range(2, 0));
            a    = 32'h200 + (32'($urandom_range(7, 0)) << 2)
                 + (32'($urandom_range(3, 0)) << 12) + 32'($urandom_range(3, 0));
            wr   = mem.exists(key_of(d, a)) ? 1'($urandom_range(1, 0)) : 1'b1;
            both = 1'($urandom_range(1, 0));
            access(d, wr, both, a, $urandom, $sformatf("rnd%0d", i));
        end

`ifdef DMEM_RESP_STATS_EN
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("final_rd%0d", i), rdc[i], 32'(exp_rd[i]));
            chk($sformatf("final_wr%0d", i), wrc[i], 32'(exp_wr[i]));
            chk($sformatf("final_st%0d", i), stc[i], 32'(exp_st[i]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
